// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default widths.
package div_pkg;

  localparam int P_W   = 5;
  localparam int M_W   = 2;
  localparam int Q_W   = 3;
  localparam int CNT_W = $clog2(P_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, conditionally subtract.
module div_step #(
  parameter int M_W = 2
) (
  input  logic [M_W:0]   rem,
  input  logic           next_bit,
  input  logic [M_W-1:0] divisor,
  output logic [M_W:0]   new_rem,
  output logic           q_bit
);

  // One bit wider than the remainder so the shifted value never wraps before the compare.
  logic [M_W+1:0] t;
  logic [M_W+1:0] diff;

  assign t    = {rem, next_bit};
  assign diff = t - {2'b00, divisor};

  always_comb begin
    q_bit   = 1'b0;
    new_rem = t[M_W:0];
    if (t >= {2'b00, divisor}) begin
      q_bit   = 1'b1;
      new_rem = diff[M_W:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/ready/valid handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int P_W = div_pkg::P_W,
  parameter int M_W = div_pkg::M_W,
  parameter int Q_W = div_pkg::Q_W
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [P_W-1:0] p,
  input  logic [M_W-1:0] m,
  output logic           ready,
  output logic           valid,
  output logic [P_W-1:0] q,
  output logic [M_W-1:0] r,
  output logic           div_by_zero,
  output logic           q_ovf
);

  localparam int CTR_W = (P_W > 1) ? $clog2(P_W) : 1;

  state_t           state;
  logic [P_W-1:0]   dividend;
  logic [M_W-1:0]   divisor;
  logic [M_W:0]     rem;
  logic [P_W-1:0]   quo;
  logic [CTR_W-1:0] cnt;

  logic [M_W:0]     new_rem;
  logic             q_bit;
  logic [P_W-1:0]   quo_next;

  div_step #(.M_W(M_W)) u_step (
    .rem      (rem),
    .next_bit (dividend[P_W-1]),
    .divisor  (divisor),
    .new_rem  (new_rem),
    .q_bit    (q_bit)
  );

  assign quo_next = {quo[P_W-2:0], q_bit};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      ready       <= 1'b1;
      valid       <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      q_ovf       <= 1'b0;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend <= p;
            divisor  <= m;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            ready    <= 1'b0;
            if (m != '0) begin
              state <= RUN;
            end else begin
              // Zero divisor skips iteration and reports a saturated quotient.
              q           <= '1;
              r           <= '0;
              div_by_zero <= 1'b1;
              q_ovf       <= 1'b1;
              valid       <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          rem      <= new_rem;
          dividend <= {dividend[P_W-2:0], 1'b0};
          quo      <= quo_next;
          cnt      <= cnt + 1'b1;
          if (cnt == CTR_W'(P_W - 1)) begin
            q           <= quo_next;
            r           <= new_rem[M_W-1:0];
            div_by_zero <= 1'b0;
            q_ovf       <= |quo_next[P_W-1:Q_W];
            valid       <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider. It is the inverse of the 2-bit x 3-bit gate-level Multiplier.
- Takes a 5-bit product-width dividend p and a 2-bit divisor m. Returns quotient q and remainder r, one quotient bit per clock.
- Sits beside Multiplier so that the pair can be verified against each other: p = m*q + r.
- Uses a start/ready/valid handshake and is driven from the same 50 MHz system clock.

Parameters:
- P_W, 5, dividend width. This is also the quotient register width and the iteration count.
- M_W, 2, divisor width. This is also the remainder width.
- Q_W, 3, width of Multiplier's q operand. Used only to compute q_ovf.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only when ready=1
- p  input  P_W  dividend, captured on accept
- m  input  M_W  divisor, captured on accept
- ready  output  1  high in IDLE only
- valid  output  1  one-cycle pulse; result outputs are meaningful from this cycle on
- q  output  P_W  quotient
- r  output  M_W  remainder
- div_by_zero  output  1  the last request had m=0
- q_ovf  output  1  the last quotient does not fit in Q_W bits (q >= 2**Q_W)

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock named clock; reset_n is synchronous and active-low.
  - With reset_n=0 at a rising edge: state=IDLE, ready=1, valid=0, q=0, r=0, div_by_zero=0, q_ovf=0, all internal registers 0.
  - Reset mid-operation aborts the division. No valid pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - At edge k with start=1: capture p into dividend shift register, m into divisor register; clear partial remainder (M_W+1 bits) and quotient register.
  - If m != 0: iteration counter=0, go to RUN.
  - If m == 0: go directly to DONE with q=all-ones, r=0, div_by_zero=1, q_ovf=1.
  - start=0: stay in IDLE.
- RUN (ready=0), one iteration per edge:
  - t = {rem[M_W-1:0], dividend MSB}.
  - If t >= divisor: rem = t - divisor, quotient bit = 1. Else rem = t, quotient bit = 0.
  - Shift the dividend left. Shift the quotient bit into the quotient LSB.
  - Increment the counter.
- End of RUN:
  - At the edge completing iteration P_W-1, i.e. edge k+P_W: load outputs q and r, div_by_zero=0, q_ovf=|q[P_W-1:Q_W], go to DONE.
- DONE:
  - valid=1 for exactly this one cycle, ready=0.
  - Next edge: go to IDLE.
- Latency: valid is high in the cycle after edge k+P_W (5 cycles for defaults). For m=0 it is the cycle after edge k.
- Throughput: one division per P_W+2 cycles. The earliest next accept is at edge k+P_W+2.
- start while ready=0 (RUN or DONE): ignored, not queued. p and m changes after accept have no effect.
- q, r, div_by_zero and q_ovf hold their values until the next result is loaded or reset.
- Arithmetic:
  - Unsigned throughout.
  - The remainder register is M_W+1 bits so the compare cannot overflow.
  - The final r always satisfies r < m.
  - Invariant for m != 0: p == m*q + r.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default widths P_W=5, M_W=2, Q_W=3;
  - the constant CNT_W = $clog2(P_W).
- One natural sub-module, div_step: a combinational single restoring iteration.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
- The FSM, counter and registers stay in seq_divider.

Test Plan:
- Basic division: p=10101 (21), m=11 -> valid after 5 cycles, q=00111, r=00, q_ovf=0, div_by_zero=0. Then p=01010, m=10 -> q=00101, r=00.
- Remainder and overflow: p=10111 (23), m=11 -> q=00111, r=10. Then p=11111, m=01 -> q=11111, r=00, q_ovf=1.
- Divide by zero: p=01100, m=00 -> valid in the cycle after the accept edge, div_by_zero=1, q=11111, r=00, q_ovf=1. The next request returns div_by_zero=0.
- Handshake: pulse start with p=10010, m=11. Re-assert start with p=00001, m=01 on the 2nd cycle of RUN -> ignored; single valid with q=00110. ready returns high one cycle after valid.
- Reset mid-operation: reset_n=0 at the 3rd RUN cycle -> no valid pulse; ready=1 and all outputs 0 on the next cycle. A fresh request p=01001, m=11 -> q=00011, r=00.
- Exhaustive pairing: for all m in 1..3 and all q in 0..7, drive p = Multiplier(m,q) -> quotient equals q, r=0, q_ovf=0. Then sweep all 32x3 (p,m) pairs with m != 0, checking p == m*q + r.
